// File: rtl/dds_am_ctrl.sv
// dds_am_ctrl: command-driven control block for an AM DDS datapath.
// Commands write shadow copies of the carrier FTW, modulating FTW and depth.
// A commit arms the block. The shadow set is then copied into the active
// outputs on the next carrier phase wrap, so the datapath retunes only on a
// carrier cycle boundary.
// Optional build macro DDS_AM_CTRL_TIMEOUT_EN adds a forced-apply timeout.
// With the timeout, a commit is applied after TIMEOUT_CYC pending cycles
// even if no carrier wrap arrives.
//
// Handshake: a command transfers on every rising clk edge where cmd_valid
// and cmd_ready are both high. cmd_ready is high only while idle. A command
// held with cmd_valid while cmd_ready is low stays pending and transfers
// later. It is never dropped.
module dds_am_ctrl #(
  parameter logic [15:0] RST_CAR_FTW = 16'd6554,
  parameter logic [15:0] RST_MOD_FTW = 16'd66,
  parameter logic [7:0]  RST_DEPTH   = 8'd128,
  parameter logic [7:0]  DEPTH_MAX   = 8'd255,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic        carrier_wrap,
  output logic [15:0] car_ftw,
  output logic [15:0] mod_ftw,
  output logic [7:0]  depth,
  output logic        cfg_update,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CAR    = 2'd0;
  localparam logic [1:0] ADDR_MOD    = 2'd1;
  localparam logic [1:0] ADDR_DEPTH  = 2'd2;
  localparam logic [1:0] ADDR_COMMIT = 2'd3;

  // The reset depth goes through the same saturation as a written depth.
  localparam logic [7:0] RST_DEPTH_SAT = (RST_DEPTH > DEPTH_MAX) ? DEPTH_MAX : RST_DEPTH;

  state_t      state_q, state_d;
  logic [15:0] sh_car_q, sh_car_d;
  logic [15:0] sh_mod_q, sh_mod_d;
  logic [7:0]  sh_depth_q, sh_depth_d;
  logic [15:0] car_q, car_d;
  logic [15:0] mod_q, mod_d;
  logic [7:0]  depth_q, depth_d;
  logic        cfg_update_q, cfg_update_d;

  logic        cmd_fire;
  logic        start_apply;

  assign cmd_fire = cmd_valid && cmd_ready;

`ifdef DDS_AM_CTRL_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_hit;

  // Pending-cycle counter. It reads zero in the first pending cycle and
  // counts each pending cycle after that.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_PENDING) to_cnt_d = to_cnt_q + 16'd1;
  end

  assign timeout_hit = (state_q == ST_PENDING) && (to_cnt_q == (TIMEOUT_CYC - 16'd1));

  // A wrap and a timeout in the same cycle give the same apply timing.
  assign start_apply = carrier_wrap || timeout_hit;

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  // Without the timeout, only a carrier wrap releases a pending commit.
  assign start_apply = carrier_wrap;

  // TIMEOUT_CYC has no function in this build.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic. A wrap seen while still idle (commit cycle) is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_fire && (cmd_addr == ADDR_COMMIT)) state_d = ST_PENDING;
      ST_PENDING: if (start_apply) state_d = ST_APPLY;
      ST_APPLY:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
  end

  // Shadow writes and active-register load.
  // The active set loads on the same edge that enters APPLY. The new values
  // and the cfg_update pulse both appear in the APPLY cycle, one cycle after
  // the wrap.
  always_comb begin
    sh_car_d     = sh_car_q;
    sh_mod_d     = sh_mod_q;
    sh_depth_d   = sh_depth_q;
    car_d        = car_q;
    mod_d        = mod_q;
    depth_d      = depth_q;
    cfg_update_d = 1'b0;
    if (cmd_fire) begin
      case (cmd_addr)
        ADDR_CAR: sh_car_d = cmd_data;
        ADDR_MOD: sh_mod_d = cmd_data;
        // Compare the full payload, so an out-of-range value such as 300
        // clamps to DEPTH_MAX instead of wrapping through its low byte.
        ADDR_DEPTH: sh_depth_d = (cmd_data > {8'h00, DEPTH_MAX}) ? DEPTH_MAX : cmd_data[7:0];
        default: ;
      endcase
    end
    if ((state_q == ST_PENDING) && start_apply) begin
      car_d        = sh_car_q;
      mod_d        = sh_mod_q;
      depth_d      = sh_depth_q;
      cfg_update_d = 1'b1;
    end
  end

  // Shadow, active and pulse registers. Reset discards any pending commit
  // and the shadow contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_car_q     <= RST_CAR_FTW;
      sh_mod_q     <= RST_MOD_FTW;
      sh_depth_q   <= RST_DEPTH_SAT;
      car_q        <= RST_CAR_FTW;
      mod_q        <= RST_MOD_FTW;
      depth_q      <= RST_DEPTH_SAT;
      cfg_update_q <= 1'b0;
    end else begin
      sh_car_q     <= sh_car_d;
      sh_mod_q     <= sh_mod_d;
      sh_depth_q   <= sh_depth_d;
      car_q        <= car_d;
      mod_q        <= mod_d;
      depth_q      <= depth_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  assign car_ftw    = car_q;
  assign mod_ftw    = mod_q;
  assign depth      = depth_q;
  assign cfg_update = cfg_update_q;

endmodule
